dcache_assoc: RTL and testbench
===============================

Name: dcache_assoc

Overview:
- Parametrised write-back, write-allocate, N-way set-associative data cache between the datapath memory port and the memory-side cache bus.
- Successor to the fixed 8-set/2-way/2-word dcache. Generalises sets, ways and block size.
- Adds true-LRU age replacement with invalid-way preference and a multi-beat block transfer engine.
- On halt: flushes every dirty line, optionally writes the hit/miss statistic, then asserts flushed.

Parameters:
- SETS, 8: number of sets; power of 2, ≥2.
- WAYS, 2: associativity; power of 2, 2..8.
- BLK_WORDS, 2: 32-bit words per block; power of 2, ≥2.
- STAT_ADDR, 32'h3100: target address of the statistic word.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request; wins if both asserted
- dmemaddr  in  32  byte address; bits[1:0] ignored
- dmemstore  in  32  write data
- halt  in  1  start flush
- dhit  out  1  request serviced this cycle
- dmemload  out  32  read data, valid when dhit
- flushed  out  1  flush complete
- dREN  out  1  memory read
- dWEN  out  1  memory write
- daddr  out  32  memory address
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; a beat completes when dwait=0

Behaviour:
- Address split, LSB first: 2 byte bits | log2(BLK_WORDS) blkoff | log2(SETS) idx | tag (remainder).
- Line state: valid, dirty, tag, BLK_WORDS data words. Per set: WAYS age fields, each log2(WAYS) bits.
- Reset: all lines invalid and clean; ages of way w = w; state IDLE; counters 0; all outputs 0.
- IDLE, hit (valid and tag match in exactly one way) with a request:
  - dhit=1 combinationally, same cycle.
  - Read: dmemload = word[blkoff].
  - Write: word[blkoff] updated at the clock edge; dirty=1.
  - Hit count +1.
- Ages update on every hit and every fill: accessed way age←0; ways with age < old age +1; others unchanged.
- IDLE, miss: victim latched.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - Miss count +1.
  - Victim dirty → WB; else → LD.
- WB: BLK_WORDS beats. Beat i: dWEN=1, daddr={victim tag, idx, i, 2'b00}, dstore=word[i]. Beat counter advances only when dwait=0. Last beat → LD.
- LD: BLK_WORDS beats. Beat i: dREN=1, daddr={req tag, idx, i, 2'b00}. On dwait=0, word[i]←dload. Last beat sets valid=1, dirty=0, tag, updates ages → IDLE.
- The request replays in the next IDLE cycle and hits. Miss latency with no stalls = (dirty ? BLK_WORDS : 0) + BLK_WORDS + 1 cycles to dhit.
- dhit is 0 in every non-IDLE state.
- The datapath holds the request stable until dhit. An address change during a miss is not supported.
- halt in IDLE has priority over any request → FSCAN. Any in-progress WB/LD completes before halt is honoured.
- FSCAN: one cycle per line, index k = 0..SETS*WAYS-1 (set = k / WAYS, way = k % WAYS).
  - Dirty line → FWB; clean line → k+1.
  - After the last line → STAT if HIT_STAT_EN, else HALTED.
- FWB: BLK_WORDS beats, addressed as in WB. After the last beat: line dirty=0, valid=0 → FSCAN at k+1.
- HALTED: flushed=1, stays until reset; requests are ignored.
- Counters: 32-bit, wrap silently.
- Reset mid-transfer aborts immediately and asynchronously; no partial line becomes valid.

Optional Feature:
- Macro: HIT_STAT_EN.
- Defined: 32-bit hit and miss counters exist. After the flush, state STAT performs one beat: dWEN=1, daddr=STAT_ADDR, dstore=hits−misses (mod 2^32), held until dwait=0 → HALTED.
- Undefined: no counters and no STAT state; flush goes directly to HALTED. Flush timing is otherwise identical.

Test Plan (defaults; idx=addr[5:3], tag=addr[31:6]):
- Cold read 0x40, dwait=0, dload=0xA0 then 0xA4 → LD beats daddr 0x40, 0x44; dhit=1 with dmemload=0xA0 on cycle 3.
- Write 0x00←0x11 (miss, fill, hit, dirty), read 0x40, then read 0x80 → way of 0x00 evicted: WB daddr 0x00 dstore 0x11, daddr 0x04; then LD 0x80, 0x84. The 0x40 line is retained.
- Read miss with dwait held high 5 cycles per beat → daddr/dREN stable throughout; dhit only after both beats; total 13 cycles.
- Dirty lines at set 2 way 0 and set 7 way 1, then halt → exactly 4 writes (0x?10/0x?14, 0x?38/0x?3C with matching tags). Then, with HIT_STAT_EN: a write to 0x3100 of hits−misses. Then flushed=1.
- Reset asserted during WB beat 1 → dWEN and dREN drop immediately; after release, a read of the victim address misses.
- Read a valid line at ages {0,1}, then access way 1 → ages become {1,0}; next miss in the set evicts way 0.

Source files
------------

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate N-way set-associative data cache with true-LRU ages; optional HIT_STAT_EN adds hit/miss counters and a statistic write after the halt flush.
// Latency: hits answer combinationally in the same cycle; a miss takes (dirty victim ? BLK_WORDS : 0) + BLK_WORDS + 1 cycles with no memory stalls.
// Backpressure: every memory beat is held until dwait=0; the datapath holds its request until dhit.
module dcache_assoc #(
    parameter int          SETS      = 8,
    parameter int          WAYS      = 2,
    parameter int          BLK_WORDS = 2,
    parameter logic [31:0] STAT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int BW = $clog2(BLK_WORDS);
    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int TW = 30 - BW - IW;
    localparam int KW = IW + WW;

    typedef enum logic [2:0] {IDLE, WB, LD, FSCAN, FWB, STAT, HALTED} state_t;
`ifdef HIT_STAT_EN
    localparam state_t FLUSH_DONE = STAT;
`else
    localparam state_t FLUSH_DONE = HALTED;
`endif

    state_t state, state_n;

    logic              valid [SETS][WAYS];
    logic              dirty [SETS][WAYS];
    logic [TW-1:0]     tags  [SETS][WAYS];
    logic [WW-1:0]     age   [SETS][WAYS];
    logic [31:0]       data  [SETS][WAYS][BLK_WORDS];

    logic [BW-1:0]     beat;
    logic [WW-1:0]     vic;
    logic [KW-1:0]     kcnt;
`ifdef HIT_STAT_EN
    logic [31:0]       hits, misses;
`endif

    logic [TW-1:0]     req_tag;
    logic [IW-1:0]     req_idx;
    logic [BW-1:0]     req_off;
    logic              req;
    logic              hit;
    logic [WW-1:0]     hit_way;
    logic [WW-1:0]     vic_way;
    logic              inv_found;
    logic [IW-1:0]     fl_set;
    logic [WW-1:0]     fl_way;
    logic              last_beat;
    logic              last_line;
    logic              beat_done;
    logic              miss_ev;
    logic              ld_fill;
    logic              fwb_end;
    logic              upd_en;
    logic [IW-1:0]     upd_set;
    logic [WW-1:0]     upd_way;
    logic              unused_addr;

    assign req_tag     = dmemaddr[31 -: TW];
    assign req_idx     = dmemaddr[2 + BW +: IW];
    assign req_off     = dmemaddr[2 +: BW];
    assign req         = dmemREN | dmemWEN;
    assign fl_set      = kcnt[KW-1:WW];
    assign fl_way      = kcnt[WW-1:0];
    assign last_beat   = (beat == BW'(BLK_WORDS - 1));
    assign last_line   = (kcnt == KW'(SETS * WAYS - 1));
    assign beat_done   = !dwait;
    assign ld_fill     = (state == LD) && beat_done && last_beat;
    assign fwb_end     = (state == FWB) && beat_done && last_beat;
    assign dmemload    = data[req_idx][hit_way][req_off];
    assign unused_addr = ^dmemaddr[1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // The oldest way is the fallback; the first invalid way, if any, overrides it.
    always_comb begin
        vic_way   = '0;
        inv_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[req_idx][w] == WW'(WAYS - 1))
                vic_way = WW'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[req_idx][w] && !inv_found) begin
                vic_way   = WW'(w);
                inv_found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        dhit    = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = '0;
        dstore  = '0;
        flushed = 1'b0;
        miss_ev = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_n = FSCAN;
                end else if (req) begin
                    if (hit) begin
                        dhit = 1'b1;
                    end else begin
                        miss_ev = 1'b1;
                        state_n = dirty[req_idx][vic_way] ? WB : LD;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tags[req_idx][vic], req_idx, beat, 2'b00};
                dstore = data[req_idx][vic][beat];
                if (beat_done && last_beat) state_n = LD;
            end
            LD: begin
                dREN  = 1'b1;
                daddr = {req_tag, req_idx, beat, 2'b00};
                if (beat_done && last_beat) state_n = IDLE;
            end
            FSCAN: begin
                if (dirty[fl_set][fl_way]) state_n = FWB;
                else if (last_line)        state_n = FLUSH_DONE;
            end
            FWB: begin
                dWEN   = 1'b1;
                daddr  = {tags[fl_set][fl_way], fl_set, beat, 2'b00};
                dstore = data[fl_set][fl_way][beat];
                if (beat_done && last_beat) state_n = last_line ? FLUSH_DONE : FSCAN;
            end
`ifdef HIT_STAT_EN
            STAT: begin
                dWEN   = 1'b1;
                daddr  = STAT_ADDR;
                dstore = hits - misses;
                if (beat_done) state_n = HALTED;
            end
`endif
            HALTED: flushed = 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        upd_en  = 1'b0;
        upd_set = req_idx;
        upd_way = hit_way;
        if (dhit) begin
            upd_en = 1'b1;
        end else if (ld_fill) begin
            upd_en  = 1'b1;
            upd_way = vic;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            beat <= '0;
            vic  <= '0;
            kcnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= WW'(w);
                end
            end
        end else begin
            if ((state == WB || state == LD || state == FWB) && beat_done)
                beat <= last_beat ? '0 : beat + BW'(1);
            if (miss_ev)
                vic <= vic_way;
            if ((state == FSCAN && !dirty[fl_set][fl_way] && !last_line) || fwb_end)
                kcnt <= kcnt + KW'(1);
            if (dhit && dmemWEN)
                dirty[req_idx][hit_way] <= 1'b1;
            if (ld_fill) begin
                valid[req_idx][vic] <= 1'b1;
                dirty[req_idx][vic] <= 1'b0;
            end
            if (fwb_end) begin
                valid[fl_set][fl_way] <= 1'b0;
                dirty[fl_set][fl_way] <= 1'b0;
            end
            // True LRU: the touched way becomes youngest, everything younger than it ages by one.
            if (upd_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == upd_way)
                        age[upd_set][w] <= '0;
                    else if (age[upd_set][w] < age[upd_set][upd_way])
                        age[upd_set][w] <= age[upd_set][w] + WW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (dhit && dmemWEN)
            data[req_idx][hit_way][req_off] <= dmemstore;
        if (state == LD && beat_done) begin
            data[req_idx][vic][beat] <= dload;
            if (last_beat) tags[req_idx][vic] <= req_tag;
        end
    end

`ifdef HIT_STAT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hits   <= '0;
            misses <= '0;
        end else begin
            if (dhit)    hits   <= hits + 32'd1;
            if (miss_ev) misses <= misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: stimulus pushes expected memory beats and hit responses, a monitor pops and compares.
module tb_dcache_assoc;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, halt;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit, flushed, dREN, dWEN, dwait;
    logic [31:0] dmemload, daddr, dstore, dload;

    dcache_assoc dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 CLK = ~CLK;

    // Memory model: every word reads as its address plus 0x60; each beat stalls for 'stall' cycles.
    int         stall = 0;
    logic [7:0] wcnt;
    assign dload = daddr + 32'h60;
    assign dwait = (dREN | dWEN) && (int'(wcnt) < stall);
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)                     wcnt <= '0;
        else if (!(dREN | dWEN) || !dwait) wcnt <= '0;
        else                           wcnt <= wcnt + 8'd1;
    end

    typedef struct { logic wen; logic [31:0] addr; logic [31:0] dat; } beat_t;
    typedef struct { logic rd; logic [31:0] dat; } hit_t;
    beat_t mem_q[$];
    hit_t  hit_q[$];
    beat_t b;
    hit_t  h;
    int    checks = 0;
    int    failures = 0;

    always @(negedge CLK) begin
        if (nRST) begin
            if (dhit) begin
                checks++;
                if (hit_q.size() == 0) begin
                    failures++;
                    $display("FAIL hit_unexpected addr=%h", dmemaddr);
                end else begin
                    h = hit_q.pop_front();
                    if (h.rd && dmemload !== h.dat) begin
                        failures++;
                        $display("FAIL hit_data addr=%h got=%h exp=%h", dmemaddr, dmemload, h.dat);
                    end
                end
            end
            if ((dREN | dWEN) && !dwait) begin
                checks++;
                if (mem_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected wen=%b addr=%h", dWEN, daddr);
                end else begin
                    b = mem_q.pop_front();
                    if (dWEN !== b.wen || dREN !== !b.wen || daddr !== b.addr || (b.wen && dstore !== b.dat)) begin
                        failures++;
                        $display("FAIL beat got wen=%b ren=%b addr=%h dat=%h exp wen=%b addr=%h dat=%h",
                                 dWEN, dREN, daddr, dstore, b.wen, b.addr, b.dat);
                    end
                end
            end else if ((dREN | dWEN) && dwait && mem_q.size() > 0) begin
                checks++;
                if (daddr !== mem_q[0].addr || dWEN !== mem_q[0].wen || dhit !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_hold got addr=%h wen=%b dhit=%b exp addr=%h wen=%b dhit=0",
                             daddr, dWEN, dhit, mem_q[0].addr, mem_q[0].wen);
                end
            end
        end
    end

    task automatic exp_beat(input logic wen, input logic [31:0] a, input logic [31:0] d);
        beat_t x;
        x.wen = wen; x.addr = a; x.dat = d;
        mem_q.push_back(x);
    endtask

    task automatic exp_ld(input logic [31:0] a);
        exp_beat(1'b0, a, 32'h0);
        exp_beat(1'b0, a + 32'd4, 32'h0);
    endtask

    task automatic exp_hit(input logic rd, input logic [31:0] d);
        hit_t x;
        x.rd = rd; x.dat = d;
        hit_q.push_back(x);
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d, input int exp_lat);
        int cyc;
        @(posedge CLK); #1;
        dmemaddr = a; dmemstore = d; dmemWEN = wr; dmemREN = !wr;
        cyc = 0;
        @(negedge CLK);
        while (!dhit && cyc < 300) begin
            cyc++;
            @(negedge CLK);
        end
        checks++;
        if (cyc != exp_lat) begin
            failures++;
            $display("FAIL latency addr=%h got=%0d exp=%0d", a, cyc, exp_lat);
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({dhit, flushed, dREN, dWEN} !== 4'b0 || daddr !== 32'h0 || dstore !== 32'h0) begin
            failures++;
            $display("FAIL %s got dhit=%b flushed=%b dREN=%b dWEN=%b daddr=%h dstore=%h exp all zero",
                     name, dhit, flushed, dREN, dWEN, daddr, dstore);
        end
    endtask

    initial begin
        int  cyc;
        logic seen;
        nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
        dmemaddr = 32'h0; dmemstore = 32'h0;
        #12;
        check_idle_outputs("reset_state");
        nRST = 1'b1;

        // Cold read fills way 0 of set 0.
        exp_ld(32'h40); exp_hit(1'b1, 32'hA0);
        req(1'b0, 32'h40, 0, 3);
        // Write-allocate into way 1, then line becomes dirty.
        exp_ld(32'h00); exp_hit(1'b0, 0);
        req(1'b1, 32'h00, 32'h11, 3);
        exp_hit(1'b1, 32'hA0);
        req(1'b0, 32'h40, 0, 0);
        // Dirty 0x00 line is the LRU victim: write-back then fill.
        exp_beat(1'b1, 32'h00, 32'h11); exp_beat(1'b1, 32'h04, 32'h64);
        exp_ld(32'h80); exp_hit(1'b1, 32'hE0);
        req(1'b0, 32'h80, 0, 5);
        exp_hit(1'b1, 32'hA0);
        req(1'b0, 32'h40, 0, 0);
        // Touching way 1 makes way 0 the victim of the next miss.
        exp_hit(1'b1, 32'hE0);
        req(1'b0, 32'h80, 0, 0);
        exp_ld(32'hC0); exp_hit(1'b1, 32'h120);
        req(1'b0, 32'hC0, 0, 3);
        exp_hit(1'b1, 32'hE0);
        req(1'b0, 32'h80, 0, 0);
        exp_ld(32'h40); exp_hit(1'b1, 32'hA0);
        req(1'b0, 32'h40, 0, 3);
        // Stalled fill: five wait cycles per beat.
        stall = 5;
        exp_ld(32'h100); exp_hit(1'b1, 32'h160);
        req(1'b0, 32'h100, 0, 13);
        stall = 0;
        // Dirty lines at set 2 way 0 and set 7 way 1.
        exp_ld(32'h10); exp_hit(1'b0, 0);
        req(1'b1, 32'h10, 32'h55, 3);
        exp_ld(32'h38); exp_hit(1'b1, 32'h98);
        req(1'b0, 32'h38, 0, 3);
        exp_ld(32'h78); exp_hit(1'b0, 0);
        req(1'b1, 32'h7C, 32'h77, 3);

        // Flush: 13 hits and 9 misses so far.
        exp_beat(1'b1, 32'h10, 32'h55); exp_beat(1'b1, 32'h14, 32'h74);
        exp_beat(1'b1, 32'h78, 32'hD8); exp_beat(1'b1, 32'h7C, 32'h77);
`ifdef HIT_STAT_EN
        exp_beat(1'b1, 32'h3100, 32'd4);
`endif
        @(posedge CLK); #1 halt = 1'b1;
        cyc = 0;
        @(negedge CLK);
        while (!flushed && cyc < 500) begin
            cyc++;
            @(negedge CLK);
        end
        checks++;
        if (flushed !== 1'b1 || mem_q.size() != 0) begin
            failures++;
            $display("FAIL flush_done got flushed=%b pending_beats=%0d exp flushed=1 pending=0", flushed, mem_q.size());
        end
        // Requests are ignored once halted.
        #1 dmemREN = 1'b1; dmemaddr = 32'h40;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (dhit || dREN || dWEN || !flushed) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL halted_ignore got activity=1 exp activity=0");
        end
        dmemREN = 1'b0; halt = 1'b0;
        #2 nRST = 1'b0;
        #1 check_idle_outputs("reset_after_halt");
        #10 nRST = 1'b1;

        // Reset during the second write-back beat.
        exp_ld(32'h00); exp_hit(1'b0, 0);
        req(1'b1, 32'h00, 32'h11, 3);
        exp_ld(32'h40); exp_hit(1'b1, 32'hA0);
        req(1'b0, 32'h40, 0, 3);
        stall = 3;
        exp_beat(1'b1, 32'h00, 32'h11);
        @(posedge CLK); #1 dmemREN = 1'b1; dmemaddr = 32'h80;
        cyc = 0;
        @(negedge CLK);
        while (!(dWEN && daddr == 32'h4) && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
        checks++;
        if (!(dWEN && daddr == 32'h4)) begin
            failures++;
            $display("FAIL wb_beat1_reach got dWEN=%b daddr=%h exp dWEN=1 daddr=00000004", dWEN, daddr);
        end
        #2 nRST = 1'b0; dmemREN = 1'b0;
        #1;
        checks++;
        if (dWEN !== 1'b0 || dREN !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got dWEN=%b dREN=%b exp 0 0", dWEN, dREN);
        end
        stall = 0;
        #10 nRST = 1'b1;
        exp_ld(32'h00); exp_hit(1'b1, 32'h60);
        req(1'b0, 32'h00, 0, 3);

        repeat (3) @(negedge CLK);
        checks++;
        if (mem_q.size() != 0 || hit_q.size() != 0) begin
            failures++;
            $display("FAIL queues_drained got beats=%0d hits=%0d exp 0 0", mem_q.size(), hit_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
